// File: rtl/dmem_map_pkg.sv
// Shared dmem address map: MMIO page, MMIO register offsets, TX_STATUS bit
// positions and the address-region decoder. Used by the responder, by the
// surrounding wrapper and by test programs.
package dmem_map_pkg;

  // address_dmem[31:12] value that selects the MMIO window.
  localparam logic [19:0] MMIO_PAGE = 20'h00001;

  // MMIO register offsets (address_dmem[11:0]).
  localparam logic [11:0] OFF_TX_DATA   = 12'h000;
  localparam logic [11:0] OFF_TX_STATUS = 12'h001;
  localparam logic [11:0] OFF_CYCLE_CNT = 12'h002;
  localparam logic [11:0] OFF_DROP_CNT  = 12'h003;

  // TX_STATUS layout: {23'b0, full, empty, count[6:0]}.
  localparam int unsigned STATUS_COUNT_LSB = 0;
  localparam int unsigned STATUS_COUNT_W   = 7;
  localparam int unsigned STATUS_EMPTY_BIT = 7;
  localparam int unsigned STATUS_FULL_BIT  = 8;

  typedef enum logic [1:0] {
    RegionNone,
    RegionRam,
    RegionMmio
  } region_e;

  // RAM lives in page 0; the MMIO window is one page; everything else is unmapped.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [19:0] mmio_page);
    if (addr[31:12] == 20'h00000) begin
      return RegionRam;
    end else if (addr[31:12] == mmio_page) begin
      return RegionMmio;
    end else begin
      return RegionNone;
    end
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem bus between processor and responder, plus the TX byte stream.
//   address_dmem, data, wren : processor request (word address, write data, write enable)
//   q_dmem                   : read data, combinational from address_dmem
//   tx_data, tx_valid        : head byte of the TX FIFO and its valid flag
//   tx_ready                 : sink accepts the head byte on a rising edge
// The master modport is the requesting side (processor + byte sink); the slave
// modport is the responder.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output address_dmem, data, wren, tx_ready,
    input  q_dmem, tx_data, tx_valid
  );

  modport slave (
    input  address_dmem, data, wren, tx_ready,
    output q_dmem, tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// tx_fifo: registered, non-fall-through FIFO feeding the TX byte stream.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push         : enqueue push_data this edge (dropped if full and no pop)
//   pop          : dequeue the head this edge (ignored when empty)
//   head         : current head entry, 0 when empty
//   count        : occupancy, full/empty flags
//   dropped      : a push was lost this edge because the FIFO was full
module tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign count = count_q;

  // A pop frees a slot on the same edge, so a push into a full FIFO is still
  // accepted when the head is leaving.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dropped = push && full && !pop_ok;

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clock) begin
    if (push_ok && !reset) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the processor dmem interface.
// Serves a word-addressed RAM in page 0 and an MMIO window holding a TX byte
// FIFO (drained over a valid/ready stream), a free-running cycle counter and a
// saturating drop counter. Reads are combinational and side-effect free.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : dmem request/response and TX stream (slave modport)
module dmem_responder #(
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [19:0] MMIO_PAGE  = dmem_map_pkg::MMIO_PAGE
) (
  input  logic              clock,
  input  logic              reset,
  dmem_responder_if.slave   bus
);
  import dmem_map_pkg::*;

  localparam int unsigned RamAw  = $clog2(MEM_DEPTH);
  localparam int unsigned FifoCw = $clog2(FIFO_DEPTH) + 1;

  region_e          region;
  logic [11:0]      offset;
  logic             mmio_we;
  logic             ram_we;
  logic [RamAw-1:0] ram_idx;

  logic [31:0] ram_q [MEM_DEPTH];
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] status;

  logic              fifo_push, fifo_pop;
  logic [7:0]        fifo_head;
  logic [FifoCw-1:0] fifo_count;
  logic              fifo_full, fifo_empty, fifo_dropped;

  assign region  = decode_region(bus.address_dmem, MMIO_PAGE);
  assign offset  = bus.address_dmem[11:0];
  assign ram_idx = bus.address_dmem[RamAw-1:0];
  assign mmio_we = bus.wren && (region == RegionMmio);
  // RAM has no reset, so a write coinciding with reset must be masked here.
  assign ram_we  = bus.wren && (region == RegionRam) && !reset;

  assign fifo_push = mmio_we && (offset == OFF_TX_DATA);
  assign fifo_pop  = bus.tx_valid && bus.tx_ready;

  tx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(bus.data[7:0]),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .dropped  (fifo_dropped)
  );

  assign bus.tx_data  = fifo_head;
  assign bus.tx_valid = !fifo_empty;

  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_q[ram_idx] <= bus.data;
    end
  end

  always_comb begin
    // A load of CYCLE_CNT replaces the increment on that edge.
    if (mmio_we && (offset == OFF_CYCLE_CNT)) begin
      cycle_cnt_d = bus.data;
    end else begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    drop_cnt_d = drop_cnt_q;
    if (mmio_we && (offset == OFF_DROP_CNT)) begin
      drop_cnt_d = '0;
    end else if (fifo_dropped && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_comb begin
    status = '0;
    status[STATUS_FULL_BIT]  = fifo_full;
    status[STATUS_EMPTY_BIT] = fifo_empty;
    status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
  end

  always_comb begin
    bus.q_dmem = '0;
    unique case (region)
      RegionRam: bus.q_dmem = ram_q[ram_idx];
      RegionMmio: begin
        unique case (offset)
          OFF_TX_STATUS: bus.q_dmem = status;
          OFF_CYCLE_CNT: bus.q_dmem = cycle_cnt_q;
          OFF_DROP_CNT:  bus.q_dmem = drop_cnt_q;
          default:       bus.q_dmem = '0;
        endcase
      end
      default: bus.q_dmem = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomised checks of dmem_responder: RAM access, unmapped
// reads, TX FIFO streaming, overflow/drop counting, cycle counter wrap,
// mid-operation reset and a scoreboard-driven push/pop mix.
module tb_dmem_responder;
  import dmem_map_pkg::*;

  localparam logic [31:0] A_TXD  = 32'h0000_1000;
  localparam logic [31:0] A_ST   = 32'h0000_1001;
  localparam logic [31:0] A_CYC  = 32'h0000_1002;
  localparam logic [31:0] A_DROP = 32'h0000_1003;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  dmem_responder_if bus ();

  dmem_responder #(
    .MEM_DEPTH (4096),
    .FIFO_DEPTH(8),
    .MMIO_PAGE (20'h00001)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = 1'b1;
    tick();
    bus.wren = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
    bus.address_dmem = a;
    bus.wren         = 1'b0;
    #1;
    r = bus.q_dmem;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b1;
    bus.address_dmem = '0;
    bus.data = '0;
    bus.wren = 1'b0;
    bus.tx_ready = 1'b0;
    tick();
    tick();
    tests++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_tx: valid=%0b data=%h, want 0/00", bus.tx_valid, bus.tx_data);
    end
    reset = 1'b0;
    bus_read(A_ST, r);
    tests++;
    if (r !== 32'h080) begin
      fails++;
      $display("FAIL reset_status: got %h want 00000080", r);
    end
    bus_read(A_CYC, r);
    tests++;
    if (r !== 32'h0) begin
      fails++;
      $display("FAIL reset_cycle: got %h want 00000000", r);
    end
    bus_read(A_DROP, r);
    tests++;
    if (r !== 32'h0) begin
      fails++;
      $display("FAIL reset_drop: got %h want 00000000", r);
    end
  endtask

  task automatic test_ram();
    logic [31:0] r;
    bus_write(32'd5, 32'hDEADBEEF);
    bus_read(32'd5, r);
    tests++;
    if (r !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL ram_rd5: got %h want deadbeef", r);
    end
    bus_write(32'h2005, 32'h12345678);
    bus_read(32'h2000, r);
    tests++;
    if (r !== 32'h0) begin
      fails++;
      $display("FAIL unmapped_rd: got %h want 00000000", r);
    end
    bus_read(32'd5, r);
    tests++;
    if (r !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL ram_alias: got %h want deadbeef", r);
    end
    bus_read(32'h1004, r);
    tests++;
    if (r !== 32'h0) begin
      fails++;
      $display("FAIL mmio_unlisted: got %h want 00000000", r);
    end
  endtask

  task automatic test_stream();
    logic [31:0] r;
    logic [7:0]  exp [3];
    exp[0] = 8'h41;
    exp[1] = 8'h42;
    exp[2] = 8'h43;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(A_TXD, {24'h0, exp[i]});
    bus_read(A_ST, r);
    tests++;
    if (r !== 32'h003) begin
      fails++;
      $display("FAIL stream_status3: got %h want 00000003", r);
    end
    bus_read(A_TXD, r);
    tests++;
    if (r !== 32'h0) begin
      fails++;
      $display("FAIL txdata_read: got %h want 00000000", r);
    end
    tick();
    tests++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin
      fails++;
      $display("FAIL stream_hold: valid=%0b data=%h want 1/41", bus.tx_valid, bus.tx_data);
    end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i]) begin
        fails++;
        $display("FAIL stream_byte%0d: valid=%0b data=%h want 1/%h", i, bus.tx_valid,
                 bus.tx_data, exp[i]);
      end
      tick();
    end
    bus.tx_ready = 1'b0;
    tests++;
    if (bus.tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_empty_valid: got %0b want 0", bus.tx_valid);
    end
    bus_read(A_ST, r);
    tests++;
    if (r !== 32'h080) begin
      fails++;
      $display("FAIL stream_status_end: got %h want 00000080", r);
    end
  endtask

  task automatic test_full();
    logic [31:0] r;
    logic [7:0]  exp [8];
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(A_TXD, 32'h10 + i);
    bus_write(A_TXD, 32'h20);
    bus_write(A_TXD, 32'h21);
    bus_read(A_DROP, r);
    tests++;
    if (r !== 32'd2) begin
      fails++;
      $display("FAIL full_drop2: got %h want 00000002", r);
    end
    bus_read(A_ST, r);
    tests++;
    if (r !== 32'h108) begin
      fails++;
      $display("FAIL full_status: got %h want 00000108", r);
    end
    // Push while the head leaves on the same edge.
    bus.tx_ready = 1'b1;
    bus_write(A_TXD, 32'h30);
    bus.tx_ready = 1'b0;
    bus_read(A_ST, r);
    tests++;
    if (r !== 32'h108) begin
      fails++;
      $display("FAIL full_pushpop_status: got %h want 00000108", r);
    end
    bus_read(A_DROP, r);
    tests++;
    if (r !== 32'd2) begin
      fails++;
      $display("FAIL full_pushpop_drop: got %h want 00000002", r);
    end
    for (int i = 0; i < 7; i++) exp[i] = 8'h11 + 8'(i);
    exp[7] = 8'h30;
    tick();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i]) begin
        fails++;
        $display("FAIL full_drain%0d: valid=%0b data=%h want 1/%h", i, bus.tx_valid,
                 bus.tx_data, exp[i]);
      end
      tick();
    end
    bus.tx_ready = 1'b0;
    tests++;
    if (bus.tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_drained_valid: got %0b want 0", bus.tx_valid);
    end
  endtask

  task automatic test_cycle_cnt();
    logic [31:0] r;
    logic [31:0] exp [3];
    exp[0] = 32'hFFFFFFFE;
    exp[1] = 32'hFFFFFFFF;
    exp[2] = 32'h00000000;
    bus_write(A_CYC, 32'hFFFFFFFE);
    for (int i = 0; i < 3; i++) begin
      bus_read(A_CYC, r);
      tests++;
      if (r !== exp[i]) begin
        fails++;
        $display("FAIL cycle_wrap%0d: got %h want %h", i, r, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] r;
    bus_write(32'd6, 32'h00001111);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(A_TXD, 32'h50 + i);
    // Write to RAM on the reset edge must be discarded.
    reset = 1'b1;
    bus.address_dmem = 32'd6;
    bus.data = 32'h00002222;
    bus.wren = 1'b1;
    tick();
    reset = 1'b0;
    bus.wren = 1'b0;
    bus_read(A_CYC, r);
    tests++;
    if (r !== 32'h0) begin
      fails++;
      $display("FAIL rst_cycle: got %h want 00000000", r);
    end
    tests++;
    if (bus.tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid: got %0b want 0", bus.tx_valid);
    end
    bus_read(A_ST, r);
    tests++;
    if (r !== 32'h080) begin
      fails++;
      $display("FAIL rst_status: got %h want 00000080", r);
    end
    bus_read(A_DROP, r);
    tests++;
    if (r !== 32'h0) begin
      fails++;
      $display("FAIL rst_drop: got %h want 00000000", r);
    end
    bus_read(32'd5, r);
    tests++;
    if (r !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rst_ram5: got %h want deadbeef", r);
    end
    bus_read(32'd6, r);
    tests++;
    if (r !== 32'h00001111) begin
      fails++;
      $display("FAIL rst_ram_write_ignored: got %h want 00001111", r);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0]  q [$];
    logic [31:0] r;
    logic [31:0] exp_st;
    int          mdrop = 0;
    logic        do_push, do_ready;
    logic [7:0]  b;
    for (int n = 0; n < 300; n++) begin
      do_push  = ($urandom_range(0, 3) != 0);
      do_ready = ($urandom_range(0, 2) == 0);
      b        = 8'($urandom);
      bus.address_dmem = A_TXD;
      bus.data         = {24'h0, b};
      bus.wren         = do_push;
      bus.tx_ready     = do_ready;
      #1;
      tests++;
      if (bus.tx_valid !== (q.size() != 0)) begin
        fails++;
        $display("FAIL rand_valid@%0d: got %0b want %0b", n, bus.tx_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        tests++;
        if (bus.tx_data !== q[0]) begin
          fails++;
          $display("FAIL rand_data@%0d: got %h want %h", n, bus.tx_data, q[0]);
        end
      end
      @(posedge clock);
      if (do_ready && q.size() != 0) void'(q.pop_front());
      if (do_push) begin
        if (q.size() < 8) q.push_back(b);
        else mdrop++;
      end
      #1;
    end
    bus.wren = 1'b0;
    bus.tx_ready = 1'b0;
    exp_st = {23'h0, q.size() == 8, q.size() == 0, 7'(q.size())};
    bus_read(A_ST, r);
    tests++;
    if (r !== exp_st) begin
      fails++;
      $display("FAIL rand_status: got %h want %h", r, exp_st);
    end
    bus_read(A_DROP, r);
    tests++;
    if (r !== 32'(mdrop)) begin
      fails++;
      $display("FAIL rand_drop: got %0d want %0d", r, mdrop);
    end
    bus_write(A_DROP, 32'h55);
    bus_read(A_DROP, r);
    tests++;
    if (r !== 32'h0) begin
      fails++;
      $display("FAIL drop_clear: got %h want 00000000", r);
    end
    bus.tx_ready = 1'b1;
    while (q.size() != 0) begin
      #1;
      tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== q[0]) begin
        fails++;
        $display("FAIL rand_drain: valid=%0b data=%h want 1/%h", bus.tx_valid, bus.tx_data,
                 q[0]);
      end
      void'(q.pop_front());
      tick();
    end
    bus.tx_ready = 1'b0;
    tests++;
    if (bus.tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rand_drained_valid: got %0b want 0", bus.tx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_stream();
    test_full();
    test_cycle_cnt();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
